uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio_pkg.sv | 38 +++
 rtl/uart_fifo.sv | 63 ++++++
 rtl/uart_tx_mmio.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   register offsets inside the 8-byte window, STATUS bit positions,
//   the transmit FSM state encoding and a helper that packs STATUS.
package uart_tx_mmio_pkg;

  // Byte offsets of the two 32-bit registers inside the window.
  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd4;

  // STATUS bit positions.
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // Transmit FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic full,
                                              input logic empty,
                                              input logic busy,
                                              input logic ovf);
    logic [31:0] s;
    s = '0;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_BUSY]  = busy;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo
//   Synchronous FIFO, async active-low reset of pointers and count.
//   A push is taken when the FIFO is not full, or when a pop happens in
//   the same cycle (the slot being freed is reused). A pop is taken only
//   when the FIFO is not empty. dout shows the head entry combinationally.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      write request and data
//   pop, dout      read request and head data
//   full, empty    occupancy flags
//   count          number of stored entries (0..DEPTH)
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly AW bits, so they wrap at DEPTH by themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter on the CPU data bus.
//   Window: BASE_ADDR+0 TXDATA (write pushes wdata[7:0], reads 0),
//           BASE_ADDR+4 STATUS {ovf, busy, empty, full} in bits [3:0];
//           writing STATUS with wea[0] and wdata[3] clears ovf.
//   Bus handshake: a store is a single-cycle request (wea nonzero,
//   sampled on the rising clk edge); there is no ready/stall. The byte
//   is accepted exactly when tx_push is high in that cycle, otherwise it
//   is dropped and the sticky overflow flag records the loss.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   addr, wdata, wea  data-bus address, store data, byte enables
//   rdata, sel        combinational read data, window hit
//   txd               serial output, idle high
//   tx_push, tx_byte  byte accepted this cycle and its value (debug)
//   irq_empty         FIFO empty and FSM idle
//   fsm_state         current transmit FSM state (debug)
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wea,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        txd,
  output logic        tx_push,
  output logic [7:0]  tx_byte,
  output logic        irq_empty,
  output tx_state_e   fsm_state
);

  localparam int            BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  // ---------------- address decode ----------------
  logic [31:0] offset;
  logic        is_txdata;
  logic        is_status;
  logic        push_req;
  logic        ovf_clr;

  assign offset    = addr - BASE_ADDR;
  assign sel       = (offset[31:3] == '0);
  // Word decode: only bit 2 distinguishes the two registers.
  assign is_txdata = sel && (offset[2] == REG_TXDATA[2]);
  assign is_status = sel && (offset[2] == REG_STATUS[2]);
  assign push_req  = is_txdata && wea[0];
  assign ovf_clr   = is_status && wea[0] && wdata[STAT_OVF];

  // ---------------- FIFO ----------------
  logic [7:0]                     fifo_dout;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]    fifo_count;
  logic                           fifo_pop;
  logic                           push_ok;

  tx_state_e     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          overflow;
  logic          baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);

  // The FSM loads the head byte when leaving IDLE or at the last STOP cycle.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && baud_last));
  assign push_ok  = push_req && (!fifo_full || fifo_pop);

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_push   = push_ok;
  assign tx_byte   = push_ok ? wdata[7:0] : 8'h00;
  assign irq_empty = fifo_empty && (state == ST_IDLE);
  assign fsm_state = state;

  // ---------------- overflow flag ----------------
  // A drop in the same cycle as a clear leaves the flag set: the newer
  // loss must stay visible to software.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && !push_ok) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // ---------------- read data ----------------
  always_comb begin
    rdata = '0;
    if (is_status) begin
      rdata = pack_status(fifo_full, fifo_empty, (state != ST_IDLE), overflow);
    end
  end

  // ---------------- transmit FSM ----------------
  // txd is registered: each state's line level is loaded on the edge that
  // enters the state, so it holds for exactly CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shreg <= fifo_dout;
            state <= ST_START;
            txd   <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end else begin
              txd <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              // Back-to-back frame: no idle bit between STOP and START.
              shreg <= fifo_dout;
              state <= ST_START;
              txd   <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // Bus bits this block does not decode.
  logic unused_bits;
  assign unused_bits = ^{wdata[31:8], wdata[2:0], wea[3:1], offset[1:0], fifo_count};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio
//   Directed bench for uart_tx_mmio with CLK_DIV=4 and FIFO_DEPTH=4.
module tb_uart_tx_mmio;

  localparam int          DIV   = 4;
  localparam int          DEPTH = 4;
  localparam int          FW    = 10 * DIV;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wea;
  logic [31:0] rdata;
  logic        sel;
  logic        txd;
  logic        tx_push;
  logic [7:0]  tx_byte;
  logic        irq_empty;
  logic [1:0]  fsm_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [FW-1:0] exp_q[$];

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .wdata     (wdata),
    .wea       (wea),
    .rdata     (rdata),
    .sel       (sel),
    .txd       (txd),
    .tx_push   (tx_push),
    .tx_byte   (tx_byte),
    .irq_empty (irq_empty),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected txd samples of one frame, index 0 = first START cycle.
  function automatic logic [FW-1:0] frame_of(input logic [7:0] b);
    logic [FW-1:0] f;
    for (int i = 0; i < FW; i++) begin
      if (i < DIV)           f[i] = 1'b0;
      else if (i < 9 * DIV)  f[i] = b[(i - DIV) / DIV];
      else                   f[i] = 1'b1;
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; the store is taken on the next rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                           output logic pushed, output logic [7:0] pbyte);
    addr  = a;
    wdata = d;
    wea   = we;
    #1;
    pushed = tx_push;
    pbyte  = tx_byte;
    @(posedge clk);
    #1;
    wea   = 4'b0000;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic s);
    addr = a;
    wea  = 4'b0000;
    #1;
    rd = rdata;
    s  = sel;
  endtask

  task automatic capture_frame(output logic [FW-1:0] f);
    for (int i = 0; i < FW; i++) begin
      f[i] = txd;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compare_frame(input string tag, input logic [FW-1:0] got);
    logic [FW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(got), 64'(e));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic        p;
    logic [7:0]  pb;
    logic [31:0] rd;
    logic        s;
    logic [FW-1:0] fr;
    logic [7:0]  six [6];
    logic [5:0]  pushes;
    logic        seen_low;
    int          guard;

    six[0] = 8'h10; six[1] = 8'h11; six[2] = 8'h12;
    six[3] = 8'h13; six[4] = 8'h14; six[5] = 8'h15;

    rst_n = 1'b0;
    addr  = '0;
    wdata = '0;
    wea   = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_irq_empty", irq_empty, 1'b1);
    check("rst_tx_push", tx_push, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    bus_read(BASE + 4, rd, s);
    check("rst_status", rd, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- single frame 0x55 ----
    exp_q.push_back(frame_of(8'h55));
    bus_write(BASE, 32'h55, 4'b0001, p, pb);
    check("t1_push", p, 1'b1);
    check("t1_byte", pb, 8'h55);
    check("t1_txd_before_pop", txd, 1'b1);
    check("t1_irq_busy", irq_empty, 1'b0);
    @(posedge clk);
    #1;
    capture_frame(fr);
    compare_frame("t1_frame55", fr);
    check("t1_irq_done", irq_empty, 1'b1);

    // ---- three back-to-back frames ----
    exp_q.push_back(frame_of(8'h41));
    exp_q.push_back(frame_of(8'h42));
    exp_q.push_back(frame_of(8'h43));
    fork
      begin
        logic       pp;
        logic [7:0] bb;
        bus_write(BASE, 32'h41, 4'b0001, pp, bb);
        bus_write(BASE, 32'h42, 4'b0001, pp, bb);
        bus_write(BASE, 32'h43, 4'b0001, pp, bb);
      end
      begin
        logic [FW-1:0] f2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
          capture_frame(f2);
          compare_frame($sformatf("t2_frame%0d", k), f2);
        end
      end
    join
    check("t2_irq_done", irq_empty, 1'b1);

    // ---- overflow: 6 stores in 6 cycles ----
    for (int k = 0; k < 6; k++) begin
      bus_write(BASE, {24'h0, six[k]}, 4'b0001, p, pb);
      pushes[k] = p;
    end
    check("t3_push_pattern", pushes, 6'b011111);
    bus_read(BASE + 4, rd, s);
    check("t3_status_ovf_full", rd, 32'hD);
    check("t3_sel_status", s, 1'b1);
    @(posedge clk);
    #1;
    bus_write(BASE + 4, 32'h8, 4'b0001, p, pb);
    check("t3_clear_no_push", p, 1'b0);
    bus_read(BASE + 4, rd, s);
    check("t3_status_cleared", rd, 32'h5);

    // ---- push on the last STOP cycle with a full FIFO ----
    guard = 0;
    @(posedge clk);
    #1;
    while (fsm_state != 2'd3 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("t4_reach_stop", (guard < 200), 1'b1);
    repeat (DIV - 1) begin
      @(posedge clk);
      #1;
    end
    bus_write(BASE, 32'h99, 4'b0001, p, pb);
    check("t4_push_on_pop", p, 1'b1);
    check("t4_byte_on_pop", pb, 8'h99);
    bus_read(BASE + 4, rd, s);
    check("t4_status_no_ovf", rd, 32'h5);
    exp_q.push_back(frame_of(8'h11));
    capture_frame(fr);
    compare_frame("t4_next_frame", fr);

    // ---- reset during DATA bit 3 of 0x12 ----
    repeat (4 + 3 * DIV + 1) begin
      @(posedge clk);
      #1;
    end
    check("t5_bit3_level", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_async_txd", txd, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_read(BASE + 4, rd, s);
    check("t5_status_after_rst", rd, 32'h2);
    seen_low = 1'b0;
    for (int k = 0; k < 6 * DIV * 10 / 4; k++) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1) seen_low = 1'b1;
    end
    check("t5_no_frames", seen_low, 1'b0);
    check("t5_irq_empty", irq_empty, 1'b1);

    // ---- decode edges ----
    bus_read(BASE + 8, rd, s);
    check("t6_sel_outside", s, 1'b0);
    check("t6_rdata_outside", rd, 32'h0);
    bus_read(BASE, rd, s);
    check("t6_txdata_reads0", rd, 32'h0);
    check("t6_sel_txdata", s, 1'b1);
    bus_write(BASE, 32'hA5, 4'b0000, p, pb);
    check("t6_wea0_no_push", p, 1'b0);
    check("t6_wea0_byte", pb, 8'h00);
    bus_read(BASE + 4, rd, s);
    check("t6_status_still_empty", rd, 32'h2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
